ex_mem_elastic_reg: RTL

Parametrised, elastic EX→MEM pipeline register. It carries the ALU result, store data and a control-bit vector (MemWrite, MemRead, MemtoReg, PCS and future additions) from EX to MEM. Unlike a fixed always-load register, it implements a valid/ready handshake with a two-entry skid buffer, so a MEM-side stall (e.g. multi-cycle data memory) never needs a combinational ready path back into EX. It also supports a flush that inserts a bubble, and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_slot.sv | 45 ++++
 rtl/ex_mem_elastic_reg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions for the EX->MEM boundary.
//   DATA_W / CTRL_W      : default datapath and control-vector widths
//   CTRL_*               : bit positions inside the control vector
//   ex_mem_payload_t     : one EX->MEM entry {alu, wdata, ctrl}
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CTRL_W = 4;

    // Control-vector bit indices; new control bits are appended above CTRL_PCS.
    localparam int unsigned CTRL_MEMWRITE = 0;
    localparam int unsigned CTRL_MEMREAD  = 1;
    localparam int unsigned CTRL_MEMTOREG = 2;
    localparam int unsigned CTRL_PCS      = 3;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [CTRL_W-1:0] ctrl;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// ----------------------------------------------------------------------------
// pipe_slot
// One storage slot of the elastic register: a valid bit plus a payload word.
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset (clears valid and payload)
//   load   in   capture d and mark the slot valid
//   clr    in   invalidate the slot and zero the payload (wins over load)
//   d      in   payload to capture
//   valid  out  slot holds an entry
//   q      out  held payload
// ----------------------------------------------------------------------------
module pipe_slot #(
    parameter int unsigned W = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Clearing zeroes the whole payload so the control field of an empty
    // slot can never carry a stale MemWrite.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= d;
        end
    end

    assign valid = valid_q;
    assign q     = data_q;

endmodule

// File: rtl/ex_mem_elastic_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_elastic_reg
// Elastic EX->MEM pipeline register with a two-entry skid buffer. in_ready
// comes straight from a flop (SKID empty), so a MEM stall never creates a
// combinational path back into EX.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   in_valid   in   EX presents an instruction
//   in_ready   out  register can accept (registered)
//   in_alu     in   ALU result / memory address
//   in_wdata   in   store data
//   in_ctrl    in   control bits (indices in pipe_pkg)
//   flush      in   drop held and incoming entries
//   out_valid  out  head entry valid
//   out_ready  in   MEM consumes the head entry
//   out_alu    out  head ALU result
//   out_wdata  out  head store data
//   out_ctrl   out  head control bits, zero whenever out_valid=0
//   stall_cnt  out  saturating count of cycles with out_valid & !out_ready
// ----------------------------------------------------------------------------
module ex_mem_elastic_reg #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_wdata,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    localparam int unsigned PW = 2 * DATA_W + CTRL_W;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // Payload layout inside a slot: {alu, wdata, ctrl}
    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;

    logic main_valid;
    logic skid_valid;
    logic main_load;
    logic main_clr;
    logic main_src_skid;
    logic skid_load;
    logic skid_clr;

    logic accept;
    logic drain;

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    assign in_pl    = {in_alu, in_wdata, in_ctrl};
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = main_valid && out_ready;

    // ------------------------------------------------------------------
    // Slot control
    // ------------------------------------------------------------------
    always_comb begin
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_src_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;

        if (flush) begin
            // A drain in this cycle has already been seen by MEM; dropping
            // everything is therefore correct in every occupancy state.
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case ({main_valid, skid_valid})
                2'b00: begin
                    main_load = accept;
                end
                2'b10: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                    end else if (drain) begin
                        main_clr = 1'b1;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only a drain can move state.
                    if (drain) begin
                        main_load     = 1'b1;
                        main_src_skid = 1'b1;
                        skid_clr      = 1'b1;
                    end
                end
                default: begin
                    // SKID-only is unreachable; recover to EMPTY.
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_d = main_src_skid ? skid_q : in_pl;

    pipe_slot #(
        .W(PW)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .clr  (main_clr),
        .d    (main_d),
        .valid(main_valid),
        .q    (main_q)
    );

    pipe_slot #(
        .W(PW)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .clr  (skid_clr),
        .d    (in_pl),
        .valid(skid_valid),
        .q    (skid_q)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = main_valid;
    assign out_alu   = main_q[PW-1 -: DATA_W];
    assign out_wdata = main_q[CTRL_W +: DATA_W];
    // The slot already zeroes ctrl on clear; the mask makes the bubble
    // guarantee independent of how the slot got empty.
    assign out_ctrl  = main_valid ? main_q[CTRL_W-1:0] : '0;

    // ------------------------------------------------------------------
    // Stall counter: saturating, untouched by flush
    // ------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (main_valid && !out_ready && (stall_q != CntMax)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

endmodule
